nmr_voter: RTL and testbench

Parametrised N-modular-redundancy voter: the registered successor to the fixed 5-input single-bit majority gate in the FMR datapath. It takes N replicated W-bit channel words and produces a bitwise majority word one cycle later. It tracks consecutive disagreements per channel and flags a channel as faulted after a threshold, optionally removing it from the vote. It sits between the replicated compute units and downstream consumers.

---
 rtl/nmr_voter.sv | 164 ++++++++++++++++
 tb/tb_nmr_voter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/nmr_voter.sv
// rtl/nmr_voter.sv - registered N-modular-redundancy bitwise majority voter with per-channel fault tracking
//
// Purpose:
//   Votes bitwise across N replicated W-bit channel words and registers the
//   result (latency 1, one vote per cycle, no backpressure). Each channel has a
//   saturating counter of consecutive disagreements with the voted word; when it
//   reaches FAULT_THRESH the channel's sticky fault flag sets.
//
// Optional feature:
//   NMR_FAULT_MASK_EN - when defined, faulted channels are removed from the vote
//   (even active counts then allow ties). When undefined, all N channels always
//   vote and the fault flags are monitor-only.
//
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous active-high reset
//   in_valid      din holds a word set to vote on this cycle
//   din           N*W channel words, channel i at [i*W +: W]
//   clear_faults  synchronous clear of all fault flags and counters
//   out_valid     dout holds a new voted word
//   dout          voted word
//   disagree      per-channel mismatch against the last valid vote
//   faulted       sticky per-channel fault flags
//   no_majority   last valid vote had a tie on some bit, or no active channels
//   active_cnt    number of channels currently voting

module nmr_voter #(
  parameter int N            = 5,
  parameter int W            = 8,
  parameter int FAULT_THRESH = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  input  logic [N*W-1:0] din,
  input  logic           clear_faults,
  output logic           out_valid,
  output logic [W-1:0]   dout,
  output logic [N-1:0]   disagree,
  output logic [N-1:0]   faulted,
  output logic           no_majority,
  output logic [3:0]     active_cnt
);

  localparam int             CW     = $clog2(FAULT_THRESH + 1);
  localparam logic [CW-1:0]  THRESH = CW'(FAULT_THRESH);

  logic           r_out_valid;
  logic [W-1:0]   r_dout;
  logic [N-1:0]   r_disagree;
  logic [N-1:0]   r_faulted;
  logic           r_no_majority;
  logic [CW-1:0]  r_cnt [N];

  logic [N-1:0]   w_active;
  logic [3:0]     w_active_cnt;
  logic [3:0]     w_ones [W];
  logic [W-1:0]   w_voted;
  logic           w_tie;
  logic [N-1:0]   w_mismatch;

`ifdef NMR_FAULT_MASK_EN
  assign w_active = ~r_faulted;
`else
  assign w_active = '1;
`endif

  always_comb begin
    w_active_cnt = '0;
    for (int i = 0; i < N; i++) begin
      w_active_cnt = w_active_cnt + 4'(w_active[i]);
    end
  end

  // Per-bit count of active channels holding a 1.
  always_comb begin
    for (int b = 0; b < W; b++) begin
      w_ones[b] = '0;
      for (int i = 0; i < N; i++) begin
        w_ones[b] = w_ones[b] + 4'(w_active[i] & din[i*W + b]);
      end
    end
  end

  // ones > zeros  <=>  2*ones > active_cnt. A tie keeps the previous output
  // bit; with no active channels every bit ties, so dout holds and
  // no_majority is raised without a special case.
  always_comb begin
    w_voted = r_dout;
    w_tie   = 1'b0;
    for (int b = 0; b < W; b++) begin
      if ({w_ones[b], 1'b0} > {1'b0, w_active_cnt}) begin
        w_voted[b] = 1'b1;
      end else if ({w_ones[b], 1'b0} < {1'b0, w_active_cnt}) begin
        w_voted[b] = 1'b0;
      end else begin
        w_voted[b] = r_dout[b];
        w_tie      = 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      w_mismatch[i] = (din[i*W +: W] != w_voted);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid   <= 1'b0;
      r_dout        <= '0;
      r_disagree    <= '0;
      r_no_majority <= 1'b0;
    end else if (in_valid) begin
      r_out_valid   <= 1'b1;
      r_dout        <= w_voted;
      r_disagree    <= w_mismatch;
      r_no_majority <= w_tie;
    end else begin
      r_out_valid   <= 1'b0;
    end
  end

  // Clear has priority over any increment or fault set on the same edge.
  // Faulted channels freeze their counters; an inactive channel cannot
  // mismatch for counting purposes, so its counter clears.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_faulted <= '0;
      for (int i = 0; i < N; i++) begin
        r_cnt[i] <= '0;
      end
    end else if (clear_faults) begin
      r_faulted <= '0;
      for (int i = 0; i < N; i++) begin
        r_cnt[i] <= '0;
      end
    end else if (in_valid && (w_active_cnt != 4'd0)) begin
      for (int i = 0; i < N; i++) begin
        if (!r_faulted[i]) begin
          if (w_active[i] && w_mismatch[i]) begin
            if (r_cnt[i] != THRESH) begin
              r_cnt[i] <= r_cnt[i] + CW'(1);
            end
            if ((r_cnt[i] + CW'(1)) == THRESH) begin
              r_faulted[i] <= 1'b1;
            end
          end else begin
            r_cnt[i] <= '0;
          end
        end
      end
    end
  end

  assign out_valid   = r_out_valid;
  assign dout        = r_dout;
  assign disagree    = r_disagree;
  assign faulted     = r_faulted;
  assign no_majority = r_no_majority;
  assign active_cnt  = w_active_cnt;

endmodule

// File: tb/tb_nmr_voter.sv
// tb/tb_nmr_voter.sv - directed self-checking bench for nmr_voter (N=5, W=8, FAULT_THRESH=4)

module tb_nmr_voter;

  localparam int N = 5;
  localparam int W = 8;

  logic           clk;
  logic           rst;
  logic           in_valid;
  logic [N*W-1:0] din;
  logic           clear_faults;
  logic           out_valid;
  logic [W-1:0]   dout;
  logic [N-1:0]   disagree;
  logic [N-1:0]   faulted;
  logic           no_majority;
  logic [3:0]     active_cnt;

  int n_tests;
  int n_fail;

  nmr_voter #(.N(N), .W(W), .FAULT_THRESH(4)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .din          (din),
    .clear_faults (clear_faults),
    .out_valid    (out_valid),
    .dout         (dout),
    .disagree     (disagree),
    .faulted      (faulted),
    .no_majority  (no_majority),
    .active_cnt   (active_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_din(input logic [7:0] c0, input logic [7:0] c1, input logic [7:0] c2,
                         input logic [7:0] c3, input logic [7:0] c4);
    din = {c4, c3, c2, c1, c0};
  endtask

  // Inputs are driven at the falling edge; outputs are sampled at the next
  // falling edge, half a cycle after the active edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    rst = 1'b0;
  endtask

  initial begin
    n_tests      = 0;
    n_fail       = 0;
    rst          = 1'b1;
    in_valid     = 1'b0;
    clear_faults = 1'b0;
    din          = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst_dout",      32'(dout),        32'h00);
    check("rst_out_valid", 32'(out_valid),   32'd0);
    check("rst_disagree",  32'(disagree),    32'd0);
    check("rst_faulted",   32'(faulted),     32'd0);
    check("rst_no_maj",    32'(no_majority), 32'd0);
    check("rst_active",    32'(active_cnt),  32'd5);

    // Unanimous vote
    in_valid = 1'b1;
    set_din(8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5);
    step();
    check("unan_dout",      32'(dout),        32'hA5);
    check("unan_out_valid", 32'(out_valid),   32'd1);
    check("unan_disagree",  32'(disagree),    32'd0);
    check("unan_no_maj",    32'(no_majority), 32'd0);

    // 3-vs-2 split
    set_din(8'hF0, 8'hF0, 8'hF0, 8'h0F, 8'h0F);
    step();
    check("split_dout",     32'(dout),     32'hF0);
    check("split_disagree", 32'(disagree), 32'b11000);

    // in_valid low: outputs hold, out_valid drops
    in_valid = 1'b0;
    set_din(8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    step();
    check("idle_out_valid", 32'(out_valid), 32'd0);
    check("idle_dout",      32'(dout),      32'hF0);
    check("idle_disagree",  32'(disagree),  32'b11000);

    // Three mismatches then an agreement resets the run
    pulse_reset();
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      set_din(8'h00, 8'h00, 8'hFF, 8'h00, 8'h00);
      step();
    end
    check("run3_faulted", 32'(faulted), 32'd0);
    set_din(8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    step();
    for (int k = 0; k < 3; k++) begin
      set_din(8'h00, 8'h00, 8'hFF, 8'h00, 8'h00);
      step();
    end
    check("rerun3_faulted", 32'(faulted), 32'd0);
    step();
    check("thresh_faulted",  32'(faulted),  32'b00100);
    check("thresh_disagree", 32'(disagree), 32'b00100);
    check("thresh_dout",     32'(dout),     32'h00);
`ifdef NMR_FAULT_MASK_EN
    check("thresh_active", 32'(active_cnt), 32'd4);
`else
    check("thresh_active", 32'(active_cnt), 32'd5);
`endif

    // clear_faults with in_valid: vote uses the pre-clear mask
    clear_faults = 1'b1;
    set_din(8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00);
    step();
    clear_faults = 1'b0;
`ifdef NMR_FAULT_MASK_EN
    check("clr_dout",   32'(dout),        32'h00);
    check("clr_no_maj", 32'(no_majority), 32'd1);
`else
    check("clr_dout",   32'(dout),        32'hFF);
    check("clr_no_maj", 32'(no_majority), 32'd0);
`endif
    check("clr_faulted", 32'(faulted),    32'd0);
    check("clr_active",  32'(active_cnt), 32'd5);

    // Fault channels 1 and 3, then vote with an even/odd active set
    pulse_reset();
    for (int k = 0; k < 4; k++) begin
      set_din(8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00);
      step();
    end
    check("f13_faulted", 32'(faulted), 32'b01010);
    set_din(8'h3C, 8'h3C, 8'h3C, 8'h3C, 8'h3C);
    step();
    check("f13_prior", 32'(dout), 32'h3C);
    set_din(8'h0F, 8'h00, 8'hF0, 8'h00, 8'hFF);
    step();
`ifdef NMR_FAULT_MASK_EN
    check("f13_active", 32'(active_cnt),  32'd3);
    check("f13_dout",   32'(dout),        32'hFF);
    check("f13_no_maj", 32'(no_majority), 32'd0);
    for (int k = 0; k < 4; k++) begin
      set_din(8'h3C, 8'h00, 8'h3C, 8'h00, 8'h00);
      step();
    end
    check("f134_faulted", 32'(faulted),    32'b11010);
    check("f134_active",  32'(active_cnt), 32'd2);
    check("f134_prior",   32'(dout),       32'h3C);
    set_din(8'h0F, 8'h00, 8'hF0, 8'h00, 8'h00);
    step();
    check("tie_dout",     32'(dout),        32'h3C);
    check("tie_no_maj",   32'(no_majority), 32'd1);
    check("tie_disagree", 32'(disagree),    32'b11111);
`else
    check("f13_active", 32'(active_cnt),  32'd5);
    check("f13_dout",   32'(dout),        32'h00);
    check("f13_no_maj", 32'(no_majority), 32'd0);
`endif

    // Asynchronous reset between edges
    set_din(8'h55, 8'h55, 8'h55, 8'h55, 8'h55);
    step();
    check("pre_arst_dout", 32'(dout), 32'h55);
    #1;
    rst = 1'b1;
    #1;
    check("arst_dout",      32'(dout),       32'h00);
    check("arst_out_valid", 32'(out_valid),  32'd0);
    check("arst_faulted",   32'(faulted),    32'd0);
    check("arst_active",    32'(active_cnt), 32'd5);
    rst      = 1'b0;
    in_valid = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
